// File: rtl/qft_pkg.sv
// rtl/qft_pkg.sv - shared constants, twiddle table and state encoding for the QFT MAC sequencer
package qft_pkg;

    localparam int W       = 17;
    localparam int FRAC    = 15;
    localparam int NPTS    = 8;
    localparam int ACC_W   = 21;
    localparam int SAT_MAX = 65535;
    localparam int SAT_MIN = -65536;

    // (1/sqrt(8)) * e^{+j*2*pi*k/8} in Q1.15
    localparam int TW_RE [NPTS] = '{11585, 8192, 0, -8192, -11585, -8192, 0, 8192};
    localparam int TW_IM [NPTS] = '{0, 8192, 11585, 8192, 0, -8192, -11585, -8192};

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_OUT
    } qft_state_e;

endpackage

// File: rtl/qft_mac_sequencer_if.sv
// rtl/qft_mac_sequencer_if.sv - input/output amplitude stream handshakes of the QFT sequencer
interface qft_mac_sequencer_if #(parameter int W = qft_pkg::W);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                in_inv;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [2:0]          out_idx;
    logic                out_last;
    logic                busy;

    modport master (
        output in_valid, in_re, in_im, in_inv, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_re, in_im, in_inv, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, busy
    );

endinterface

// File: rtl/qft_twiddle_rom.sv
// rtl/qft_twiddle_rom.sv - combinational 8-entry twiddle lookup, inverse direction conjugates
module qft_twiddle_rom
    import qft_pkg::*;
(
    input  logic [2:0]          k_i,
    input  logic                inv_i,
    output logic signed [W-1:0] tr_o,
    output logic signed [W-1:0] ti_o
);

    logic signed [W-1:0] ti_raw;

    assign tr_o   = W'(TW_RE[k_i]);
    assign ti_raw = W'(TW_IM[k_i]);
    assign ti_o   = inv_i ? -ti_raw : ti_raw;

endmodule

// File: rtl/qft_mac_sequencer.sv
// rtl/qft_mac_sequencer.sv - 8-point QFT computed as 64 sequential complex MACs on one datapath
module qft_mac_sequencer #(
    parameter int W     = qft_pkg::W,
    parameter int ACC_W = qft_pkg::ACC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    qft_mac_sequencer_if.slave   bus
);
    import qft_pkg::*;

    localparam int PW = 2 * W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

    function automatic logic signed [W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX) return W'(ACC_MAX);
        if (a < ACC_MIN) return W'(ACC_MIN);
        return W'(a);
    endfunction

    qft_state_e          state_q;
    logic [2:0]          in_cnt_q;
    logic                inv_q;
    logic [6:0]          issue_q;
    logic [2:0]          out_idx_q;
    logic signed [W-1:0] x_re_q [NPTS];
    logic signed [W-1:0] x_im_q [NPTS];
    logic signed [W-1:0] r_re_q [NPTS];
    logic signed [W-1:0] r_im_q [NPTS];

    logic                    p_vld_q;
    logic [2:0]              p_i_q, p_j_q;
    logic signed [ACC_W-1:0] p_re_q, p_im_q;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;

    logic                in_fire, issue_en, wr_last;
    logic [2:0]          iss_i, iss_j, k;
    logic signed [W-1:0] tr, ti, xr, xi;
    logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
    logic signed [ACC_W-1:0] part_re, part_im;

    assign in_fire  = (state_q == ST_LOAD) && bus.in_valid;
    // issue_q[6] marks that all 64 {j,i} pairs have been issued
    assign issue_en = (state_q == ST_COMPUTE) && !issue_q[6];
    assign iss_i    = issue_q[2:0];
    assign iss_j    = issue_q[5:3];
    assign k        = iss_i * iss_j;
    assign xr       = x_re_q[iss_i];
    assign xi       = x_im_q[iss_i];

    qft_twiddle_rom u_rom (
        .k_i   (k),
        .inv_i (inv_q),
        .tr_o  (tr),
        .ti_o  (ti)
    );

    // each product is floored by the shift before combining
    assign prod_rr = PW'(xr) * PW'(tr);
    assign prod_ii = PW'(xi) * PW'(ti);
    assign prod_ri = PW'(xr) * PW'(ti);
    assign prod_ir = PW'(xi) * PW'(tr);
    assign part_re = ACC_W'(prod_rr >>> FRAC) - ACC_W'(prod_ii >>> FRAC);
    assign part_im = ACC_W'(prod_ri >>> FRAC) + ACC_W'(prod_ir >>> FRAC);

    assign acc_re_d = ((p_i_q == 3'd0) ? '0 : acc_re_q) + p_re_q;
    assign acc_im_d = ((p_i_q == 3'd0) ? '0 : acc_im_q) + p_im_q;
    assign wr_last  = p_vld_q && (p_i_q == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            in_cnt_q  <= '0;
            inv_q     <= 1'b0;
            issue_q   <= '0;
            out_idx_q <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        in_cnt_q <= in_cnt_q + 3'd1;
                        if (in_cnt_q == 3'd0) inv_q <= bus.in_inv;
                        if (in_cnt_q == 3'd7) begin
                            state_q <= ST_COMPUTE;
                            issue_q <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (issue_en) issue_q <= issue_q + 7'd1;
                    if (wr_last && (p_j_q == 3'd7)) begin
                        state_q   <= ST_OUT;
                        out_idx_q <= '0;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_idx_q <= out_idx_q + 3'd1;
                        if (out_idx_q == 3'd7) state_q <= ST_LOAD;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_vld_q  <= 1'b0;
            p_i_q    <= '0;
            p_j_q    <= '0;
            p_re_q   <= '0;
            p_im_q   <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            for (int n = 0; n < NPTS; n++) begin
                r_re_q[n] <= '0;
                r_im_q[n] <= '0;
            end
        end else begin
            p_vld_q <= issue_en;
            p_i_q   <= iss_i;
            p_j_q   <= iss_j;
            p_re_q  <= part_re;
            p_im_q  <= part_im;
            if (p_vld_q) begin
                acc_re_q <= acc_re_d;
                acc_im_q <= acc_im_d;
            end
            if (wr_last) begin
                r_re_q[p_j_q] <= sat(acc_re_d);
                r_im_q[p_j_q] <= sat(acc_im_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            x_re_q[in_cnt_q] <= bus.in_re;
            x_im_q[in_cnt_q] <= bus.in_im;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.busy      = (state_q != ST_LOAD);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = (state_q == ST_OUT) && (out_idx_q == 3'd7);
    assign bus.out_re    = (state_q == ST_OUT) ? r_re_q[out_idx_q] : '0;
    assign bus.out_im    = (state_q == ST_OUT) ? r_im_q[out_idx_q] : '0;

endmodule

// File: tb/tb_qft_mac_sequencer.sv
// tb/tb_qft_mac_sequencer.sv - randomized self-checking bench for qft_mac_sequencer
module tb_qft_mac_sequencer;

    localparam int W = 17;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qft_mac_sequencer_if #(.W(W)) bus();

    qft_mac_sequencer #(.W(W), .ACC_W(21)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    int xr_v [8];
    int xi_v [8];
    int ye_re [8];
    int ye_im [8];

    int twr [8] = '{11585, 8192, 0, -8192, -11585, -8192, 0, 8192};
    int twi [8] = '{0, 8192, 11585, 8192, 0, -8192, -11585, -8192};

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int fl(input longint p);
        return int'(p >>> 15);
    endfunction

    function automatic int clamp(input int v);
        if (v > 65535) return 65535;
        if (v < -65536) return -65536;
        return v;
    endfunction

    task automatic model(input bit inv);
        for (int j = 0; j < 8; j++) begin
            int sr, si;
            sr = 0;
            si = 0;
            for (int i = 0; i < 8; i++) begin
                int kk, tr, ti;
                kk = (i * j) % 8;
                tr = twr[kk];
                ti = inv ? -twi[kk] : twi[kk];
                sr += fl(longint'(xr_v[i]) * tr) - fl(longint'(xi_v[i]) * ti);
                si += fl(longint'(xr_v[i]) * ti) + fl(longint'(xi_v[i]) * tr);
            end
            ye_re[j] = clamp(sr);
            ye_im[j] = clamp(si);
        end
    endtask

    task automatic clear_x();
        for (int i = 0; i < 8; i++) begin
            xr_v[i] = 0;
            xi_v[i] = 0;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ":in_ready"},  int'(bus.in_ready), 1);
        chk({tag, ":out_valid"}, int'(bus.out_valid), 0);
        chk({tag, ":out_re"},    int'(bus.out_re), 0);
        chk({tag, ":out_im"},    int'(bus.out_im), 0);
        chk({tag, ":out_idx"},   int'(bus.out_idx), 0);
        chk({tag, ":out_last"},  int'(bus.out_last), 0);
        chk({tag, ":busy"},      int'(bus.busy), 0);
    endtask

    task automatic run_xform(input string name, input bit inv, input int bp_idx, input int abort_at);
        int b, guard, wc, hold;
        model(inv);
        b = 0;
        guard = 0;
        while (b < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_re     = bus.in_valid ? W'(xr_v[b]) : W'($urandom);
            bus.in_im     = bus.in_valid ? W'(xi_v[b]) : W'($urandom);
            bus.in_inv    = (b == 0 && bus.in_valid) ? inv : 1'($urandom);
            bus.out_ready = 1'($urandom);
            if (bus.in_valid && bus.in_ready) b++;
        end
        chk({name, ":load_beats"}, b, 8);

        wc = 0;
        bus.out_ready = 1'b0;
        while (wc < 100) begin
            @(negedge clk);
            wc++;
            bus.in_valid = 1'($urandom);
            bus.in_re    = W'($urandom);
            bus.in_im    = W'($urandom);
            bus.in_inv   = 1'($urandom);
            if (wc == 1) begin
                chk({name, ":in_ready_fall"}, int'(bus.in_ready), 0);
                chk({name, ":busy_rise"},     int'(bus.busy), 1);
            end
            if (abort_at == wc) begin
                reset = 1'b1;
                @(negedge clk);
                check_idle({name, ":in_reset"});
                reset = 1'b0;
                bus.in_valid = 1'b0;
                @(negedge clk);
                check_idle({name, ":after_reset"});
                return;
            end
            if (bus.out_valid) break;
        end
        chk({name, ":latency"}, wc, 66);

        b = 0;
        hold = 0;
        guard = 0;
        while (b < 8 && guard < 100) begin
            chk({name, ":out_valid"}, int'(bus.out_valid), 1);
            chk({name, ":out_idx"},   int'(bus.out_idx), b);
            chk({name, ":out_last"},  int'(bus.out_last), int'(b == 7));
            chk({name, ":out_re"},    int'(bus.out_re), ye_re[b]);
            chk({name, ":out_im"},    int'(bus.out_im), ye_im[b]);
            chk({name, ":in_ready"},  int'(bus.in_ready), 0);
            chk({name, ":busy"},      int'(bus.busy), 1);
            if (b == bp_idx && hold < 5) begin
                bus.out_ready = 1'b0;
                hold++;
            end else begin
                bus.out_ready = ($urandom_range(3) != 0);
            end
            bus.in_valid = 1'($urandom);
            bus.in_re    = W'($urandom);
            if (bus.out_ready) b++;
            @(negedge clk);
            guard++;
        end
        chk({name, ":out_beats"}, b, 8);
        if (bp_idx >= 0) chk({name, ":bp_hold"}, hold, 5);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({name, ":end_out_valid"}, int'(bus.out_valid), 0);
        chk({name, ":end_busy"},      int'(bus.busy), 0);
        chk({name, ":end_in_ready"},  int'(bus.in_ready), 1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_inv    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        clear_x();
        xr_v[0] = 32768;
        run_xform("basis", 1'b0, -1, 0);
        chk("basis_y3_re", ye_re[3], 11585);

        clear_x();
        xr_v[1] = 32768;
        run_xform("phase_fwd", 1'b0, -1, 0);
        chk("phase_fwd_y1_im", ye_im[1], 8192);
        run_xform("phase_inv", 1'b1, -1, 0);
        chk("phase_inv_y2_im", ye_im[2], -11585);

        clear_x();
        xr_v[0] = 23170;
        xi_v[1] = 23170;
        run_xform("superpos", 1'b0, -1, 0);
        chk("superpos_y0_re", ye_re[0], 8191);

        for (int i = 0; i < 8; i++) xr_v[i] = 32768;
        for (int i = 0; i < 8; i++) xi_v[i] = 0;
        run_xform("saturate", 1'b0, -1, 0);
        chk("saturate_y0_re", ye_re[0], 65535);

        for (int i = 0; i < 8; i++) begin
            xr_v[i] = int'($urandom_range(131071)) - 65536;
            xi_v[i] = int'($urandom_range(131071)) - 65536;
        end
        run_xform("backpressure", 1'($urandom), 3, 0);

        clear_x();
        xr_v[0] = 32768;
        xi_v[5] = 20000;
        run_xform("abort", 1'b0, -1, 30);
        clear_x();
        xr_v[0] = 32768;
        run_xform("post_abort", 1'b0, -1, 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) begin
                xr_v[i] = int'($urandom_range(131071)) - 65536;
                xi_v[i] = (t < 3) ? int'($urandom_range(32767)) - 16384
                                  : int'($urandom_range(131071)) - 65536;
            end
            run_xform("random", 1'($urandom), int'($urandom_range(7)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/qft_mac_sequencer.md
# qft_mac_sequencer

Time-multiplexed 3-qubit (8-point) QFT engine built around a single complex multiply-accumulate datapath, replacing the fully parallel tensor-product array. It accepts the 8 complex input amplitudes as a streamed handshake, schedules 64 complex MACs against a twiddle ROM, and streams the 8 output amplitudes with per-beat backpressure. It sits between the amplitude source and the display/readout stage.

## Interface
Parameters:
- W, 17, amplitude width: signed Q1.15 (sign, 1 integer bit, 15 fraction bits).
- ACC_W, 21, accumulator width, signed.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input amplitude beat valid.
- in_ready  out  1  block can accept an input beat.
- in_re, in_im  in  W  input amplitude x[i]. Beats arrive in index order i=0..7.
- in_inv  in  1  transform direction, sampled on beat i=0: 0 = forward, 1 = inverse (conjugate twiddles).
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_re, out_im  out  W  output amplitude y[j], saturated.
- out_idx  out  3  j of the current output beat.
- out_last  out  1  high with out_idx==7.
- busy  out  1  high in COMPUTE and OUT.

## Operation
- Transform: y[j] = Σ_{i=0..7} x[i]·T[(i·j) mod 8]. T[k] = (1/√8)·e^{+j2πk/8}. With in_inv=1, T is conjugated.
- Twiddle values (re,im): k0 (11585,0), k1 (8192,8192), k2 (0,11585), k3 (-8192,8192), k4 (-11585,0), k5 (-8192,-8192), k6 (0,-11585), k7 (8192,-8192).
- Each real product is 34-bit full precision, then arithmetic shift right by 15 (floor).
  - Partial re = (xr·tr>>>15) − (xi·ti>>>15).
  - Partial im = (xr·ti>>>15) + (xi·tr>>>15).
- Partials are summed in the ACC_W accumulator with no intermediate saturation. The accumulator is cleared at i=0 of each j.
- The final sum saturates to [-65536, 65535] and is written to result buffer entry j.
- States:
  - LOAD (reset state): in_ready=1. Each in_valid&in_ready handshake writes x[cnt] and increments cnt. After beat 7: go to COMPUTE, in_ready=0.
  - COMPUTE: a 6-bit issue counter {j,i} steps 0..63, one MAC issued per cycle. The multiplier output is registered (1 stage) and accumulated in the next stage. After the last write (j=7): go to OUT.
  - OUT: presents result[j] for j=0..7. Advance on out_valid&out_ready. After the handshake on j=7: go to LOAD.
- The phases are exclusive, so input and output handshakes never occur in the same cycle.
- In LOAD, in_valid while out_ready is toggling has no effect on the output side.
- in_inv is captured on beat 0 only; changes on later beats are ignored.
- Reset mid-operation aborts immediately. Partial loads and results are discarded; the next load starts at i=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, busy=0. Internal counters are 0 and state is LOAD.
- Let the handshake on input beat 7 occur in cycle T:
  - in_ready falls at T+1, busy rises at T+1.
  - MAC issue runs over cycles T+1..T+64.
  - The final result write happens at T+65.
  - out_valid rises at T+66 with out_idx=0.
- out_valid stays high through all 8 beats. Data, out_idx and out_last are held stable while out_ready=0.
- After a handshake on j<7, beat j+1 is presented in the next cycle.
- After the handshake on j=7: out_valid=0, busy=0 and in_ready=1 in the next cycle.
- Best-case throughput: 8 load + 65 compute + 8 out = 81 cycles per transform.

## Structure
- Package qft_pkg holds:
  - W=17 and FRAC=15.
  - NPTS=8.
  - Saturation bounds.
  - The 8 twiddle constants.
  - The state enum {LOAD, COMPUTE, OUT}.
- Sub-module qft_twiddle_rom: combinational. Takes k[2:0] and inv, returns tr and ti in Q1.15; inv negates ti.
- The top level contains:
  - the input buffer (8×2×W);
  - the result buffer (8×2×W);
  - the counters;
  - the FSM;
  - the single complex MAC.

## Test plan
- Basis state: x0=(32768,0), others 0, forward. Expect y[0..7]=(11585,0) each, out_idx 0..7, out_last only on idx 7, out_valid first at T+66.
- Single phase: x1=(32768,0), others 0.
  - Forward: y1=(8192,8192), y2=(0,11585), y4=(-11585,0), y7=(8192,-8192).
  - Repeat with in_inv=1: all imaginary parts negated.
- Superposition: x0=(23170,0), x1=(0,23170). Expect y0=(8191,8191), confirming the per-product floor truncation.
- Saturation: all x[i]=(32768,0). Expect y0=(65535,0) saturated and y1..y7=(0,0).
- Backpressure: hold out_ready low for 5 cycles at idx 3. Expect out_re/out_im/out_idx stable, no beat skipped or duplicated, and in_ready=0 throughout.
- Reset mid-COMPUTE: assert reset at T+30. Expect all outputs at reset values and in_ready=1 after release. A fresh load of the basis-state test then produces correct results.
